tv_sequencer: RTL



---
 rtl/tv_pkg.sv | 13 +
 rtl/tv_sequencer_if.sv | 31 +++
 rtl/tv_mem.sv | 23 ++
 rtl/tv_sequencer.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/tv_pkg.sv
// Shared types and default sizing for the vector sequencer.
package tv_pkg;

   typedef enum logic [1:0] {IDLE, APPLY, CHECK, DONE} state_t;

   localparam int unsigned NIN_DEF    = 4;
   localparam int unsigned AW_DEF     = 4;
   localparam int unsigned DEPTH_DEF  = 16;
   localparam int unsigned SETTLE_DEF = 2;
   localparam int unsigned VW         = NIN_DEF + 1;
   localparam int unsigned CW         = AW_DEF + 1;

endpackage

// File: rtl/tv_sequencer_if.sv
// Control, memory-load, DUT-drive and status signals of the vector sequencer.
interface tv_sequencer_if #(
   parameter int unsigned NIN = tv_pkg::NIN_DEF,
   parameter int unsigned AW  = tv_pkg::AW_DEF
);

   logic           start;
   logic [AW:0]    num_vec;
   logic           wr_en;
   logic [AW-1:0]  wr_addr;
   logic [NIN:0]   wr_data;
   logic [NIN-1:0] dut_a;
   logic           dut_y;
   logic           busy;
   logic           done;
   logic [AW:0]    vec_count;
   logic [AW:0]    err_count;
   logic           fail_valid;
   logic [AW-1:0]  fail_idx;

   modport master (
      output start, num_vec, wr_en, wr_addr, wr_data, dut_y,
      input  dut_a, busy, done, vec_count, err_count, fail_valid, fail_idx
   );

   modport slave (
      input  start, num_vec, wr_en, wr_addr, wr_data, dut_y,
      output dut_a, busy, done, vec_count, err_count, fail_valid, fail_idx
   );

endinterface

// File: rtl/tv_mem.sv
// Vector memory: synchronous write, asynchronous read, contents not reset.
module tv_mem #(
   parameter int unsigned DEPTH = 16,
   parameter int unsigned AW    = 4,
   parameter int unsigned W     = 5
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [W-1:0]  wdata,
   input  logic [AW-1:0] raddr,
   output logic [W-1:0]  rdata
);

   logic [W-1:0] mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem_q[waddr] <= wdata;
   end

   assign rdata = mem_q[raddr];

endmodule

// File: rtl/tv_sequencer.sv
// Applies stored vectors to a combinational DUT, checks its output and
// records vector/error counts plus the first failing index.
module tv_sequencer #(
   parameter int unsigned NIN    = tv_pkg::NIN_DEF,
   parameter int unsigned DEPTH  = tv_pkg::DEPTH_DEF,
   parameter int unsigned AW     = tv_pkg::AW_DEF,
   parameter int unsigned SETTLE = tv_pkg::SETTLE_DEF
) (
   input logic          clk,
   input logic          reset,
   tv_sequencer_if.slave bus
);

   import tv_pkg::*;

   localparam int unsigned VEC_W = NIN + 1;
   localparam int unsigned CNT_W = AW + 1;
   localparam int unsigned SW    = (SETTLE > 1) ? $clog2(SETTLE) : 1;
   localparam logic [CNT_W-1:0] DEPTH_C     = CNT_W'(DEPTH);
   localparam logic [SW-1:0]    SETTLE_LAST = SW'(SETTLE - 1);

   state_t             state_q, state_d;
   logic [AW-1:0]      idx_q, idx_d;
   logic [CNT_W-1:0]   n_q, n_d;
   logic [SW-1:0]      settle_q, settle_d;
   logic               load_q, load_d;
   logic [NIN-1:0]     dut_a_q, dut_a_d;
   logic               exp_q, exp_d;
   logic [CNT_W-1:0]   vec_q, vec_d;
   logic [CNT_W-1:0]   err_q, err_d;
   logic               fv_q, fv_d;
   logic [AW-1:0]      fidx_q, fidx_d;

   logic               busy;
   logic               last_vec;
   logic [AW-1:0]      rd_addr;
   logic [VEC_W-1:0]   rd_data;
   logic [NIN-1:0]     stim;

   assign busy     = (state_q == APPLY) || (state_q == CHECK);
   assign last_vec = ({1'b0, idx_q} == (n_q - CNT_W'(1)));

   // First APPLY cycle of a run fetches mem[idx]; CHECK prefetches the next entry
   // so later vectors need no extra load cycle.
   assign rd_addr = (state_q == APPLY && load_q) ? idx_q : idx_q + AW'(1);

   tv_mem #(
      .DEPTH (DEPTH),
      .AW    (AW),
      .W     (VEC_W)
   ) u_mem (
      .clk   (clk),
      .we    (bus.wr_en && !busy),
      .waddr (bus.wr_addr),
      .wdata (bus.wr_data),
      .raddr (rd_addr),
      .rdata (rd_data)
   );

   // Stimulus field is stored a[0]-first: wr_data[NIN] drives a[0].
   always_comb begin
      stim = '0;
      for (int unsigned i = 0; i < NIN; i++) stim[i] = rd_data[NIN - i];
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         idx_q    <= '0;
         n_q      <= '0;
         settle_q <= '0;
         load_q   <= 1'b0;
         dut_a_q  <= '0;
         exp_q    <= 1'b0;
         vec_q    <= '0;
         err_q    <= '0;
         fv_q     <= 1'b0;
         fidx_q   <= '0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         n_q      <= n_d;
         settle_q <= settle_d;
         load_q   <= load_d;
         dut_a_q  <= dut_a_d;
         exp_q    <= exp_d;
         vec_q    <= vec_d;
         err_q    <= err_d;
         fv_q     <= fv_d;
         fidx_q   <= fidx_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      n_d      = n_q;
      settle_d = settle_q;
      load_d   = load_q;
      dut_a_d  = dut_a_q;
      exp_d    = exp_q;
      vec_d    = vec_q;
      err_d    = err_q;
      fv_d     = fv_q;
      fidx_d   = fidx_q;
      case (state_q)
         IDLE, DONE: begin
            if (bus.start) begin
               vec_d    = '0;
               err_d    = '0;
               fv_d     = 1'b0;
               fidx_d   = '0;
               idx_d    = '0;
               settle_d = '0;
               load_d   = 1'b1;
               n_d      = (bus.num_vec > DEPTH_C) ? DEPTH_C : bus.num_vec;
               state_d  = APPLY;
            end
         end
         APPLY: begin
            if (load_q) begin
               load_d = 1'b0;
               if (n_q == '0) begin
                  state_d = DONE;
               end else begin
                  dut_a_d = stim;
                  exp_d   = rd_data[0];
               end
            end else if (settle_q == SETTLE_LAST) begin
               settle_d = '0;
               state_d  = CHECK;
            end else begin
               settle_d = settle_q + SW'(1);
            end
         end
         CHECK: begin
            vec_d = vec_q + CNT_W'(1);
            if (bus.dut_y != exp_q) begin
               err_d = err_q + CNT_W'(1);
               if (!fv_q) begin
                  fv_d   = 1'b1;
                  fidx_d = idx_q;
               end
            end
            if (last_vec) begin
               state_d = DONE;
            end else begin
               idx_d   = idx_q + AW'(1);
               dut_a_d = stim;
               exp_d   = rd_data[0];
               state_d = APPLY;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign bus.dut_a      = dut_a_q;
   assign bus.busy       = busy;
   assign bus.done       = (state_q == DONE);
   assign bus.vec_count  = vec_q;
   assign bus.err_count  = err_q;
   assign bus.fail_valid = fv_q;
   assign bus.fail_idx   = fidx_q;

endmodule
